// File: rtl/rv_pkg.sv
// Shared RISC-V constants: XLEN, load/store decode codes, memory-stage error codes and FSM states.
package rv_pkg;
    localparam int XLEN = 32;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_TIMEOUT  = 2'd1,
        ERR_MISALIGN = 2'd2
    } err_code_e;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

    // size is funct3[1:0]: 00 byte, 01 half, anything else word
    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] addr);
        case (size)
            2'b00:   byte_en = 4'b0001 << addr;
            2'b01:   byte_en = 4'b0011 << {addr[1], 1'b0};
            default: byte_en = 4'b1111;
        endcase
    endfunction
endpackage

// File: rtl/memory_access_if.sv
// Data-memory bus between the memory stage (master) and the data memory (slave).
interface memory_access_if;
    import rv_pkg::*;

    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic [3:0]      dmem_be;
    logic            dmem_ack;
    logic [XLEN-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/load_align.sv
// Picks the addressed byte/halfword out of a load word and sign- or zero-extends it per funct3.
module load_align
    import rv_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      addr,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data
);
    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted = rdata >> {addr, 3'b000};
        case (funct3)
            F3_B:    data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            F3_H:    data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            F3_BU:   data = {{(XLEN-8){1'b0}}, shifted[7:0]};
            F3_HU:   data = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default: data = rdata;
        endcase
    end
endmodule

// File: rtl/memory_access.sv
// Pipeline memory stage: issues loads/stores on the dmem bus, stalls on wait states, times out.
// Optional MEM_MISALIGN_TRAP_EN: misaligned accesses retire with err_code 2 instead of being aligned.
module memory_access
    import rv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [XLEN-1:0]        pc_mem,
    input  logic [XLEN-1:0]        alu_mem,
    input  logic [XLEN-1:0]        rs2_mem,
    input  logic [XLEN-1:0]        instr_mem,
    input  logic                   valid_mem,
    output logic                   stall_mem,
    memory_access_if.master        bus,
    output logic [XLEN-1:0]        pc_wb,
    output logic [XLEN-1:0]        alu_wb,
    output logic [XLEN-1:0]        mem_wb,
    output logic [XLEN-1:0]        instr_wb,
    output logic                   valid_wb,
    output logic                   err_wb,
    output logic [1:0]             err_code_wb,
    output logic [XLEN-1:0]        forward_mem
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    mem_state_e      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] pc_wb_q, pc_wb_d, alu_wb_q, alu_wb_d;
    logic [XLEN-1:0] mem_wb_q, mem_wb_d, instr_wb_q, instr_wb_d;
    logic            valid_wb_q, valid_wb_d, err_wb_q, err_wb_d;
    logic [1:0]      err_code_q, err_code_d;

    logic [2:0]      f3;
    logic            is_load, is_store, memop, trap;
    logic [XLEN-1:0] addr_eff, load_data;
    logic            idle, waiting, req_issue, timeout, done_ok, done_to, pass, retire;

    assign f3       = instr_mem[14:12];
    assign is_load  = instr_mem[6:0] == OPC_LOAD;
    assign is_store = instr_mem[6:0] == OPC_STORE;
    assign memop    = is_load | is_store;

`ifdef MEM_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = (f3[1:0] == 2'b01) ? alu_mem[0] :
                        (f3[1:0] == 2'b00) ? 1'b0 : (alu_mem[1:0] != 2'b00);
    assign trap       = valid_mem & memop & misaligned;
    assign addr_eff   = alu_mem;
`else
    // Misaligned halves/words silently drop the offending low address bits.
    assign trap     = 1'b0;
    assign addr_eff = (f3[1:0] == 2'b00) ? alu_mem :
                      (f3[1:0] == 2'b01) ? {alu_mem[XLEN-1:1], 1'b0} :
                                           {alu_mem[XLEN-1:2], 2'b00};
`endif

    assign idle      = state_q == IDLE;
    assign waiting   = state_q == WAIT;
    assign req_issue = idle & valid_mem & memop & ~trap;
    assign timeout   = waiting & (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    // rst gates the strobe so a pending request vanishes in the reset cycle itself
    assign bus.dmem_req   = ~rst & (req_issue | waiting);
    assign bus.dmem_we    = is_store;
    assign bus.dmem_addr  = addr_eff;
    assign bus.dmem_be    = byte_en(f3[1:0], addr_eff[1:0]);
    assign bus.dmem_wdata = (f3[1:0] == 2'b00) ? {4{rs2_mem[7:0]}} :
                            (f3[1:0] == 2'b01) ? {2{rs2_mem[15:0]}} : rs2_mem;

    assign stall_mem = bus.dmem_req & ~bus.dmem_ack & ~timeout;

    assign done_ok = bus.dmem_req & bus.dmem_ack;
    assign done_to = timeout & ~bus.dmem_ack;
    assign pass    = idle & valid_mem & (~memop | trap);
    assign retire  = done_ok | done_to | pass;

    load_align u_load_align (
        .rdata  (bus.dmem_rdata),
        .addr   (addr_eff[1:0]),
        .funct3 (f3),
        .data   (load_data)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_wb_d    = pc_wb_q;
        alu_wb_d   = alu_wb_q;
        mem_wb_d   = mem_wb_q;
        instr_wb_d = instr_wb_q;
        err_wb_d   = err_wb_q;
        err_code_d = err_code_q;
        valid_wb_d = retire;

        case (state_q)
            IDLE: if (req_issue & ~bus.dmem_ack) begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: if (bus.dmem_ack | timeout) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            default: state_d = IDLE;
        endcase

        if (retire) begin
            pc_wb_d    = pc_mem;
            alu_wb_d   = alu_mem;
            instr_wb_d = instr_mem;
            mem_wb_d   = (is_load & done_ok) ? load_data : '0;
            err_wb_d   = done_to | trap;
            err_code_d = done_to ? ERR_TIMEOUT : (trap ? ERR_MISALIGN : ERR_NONE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            pc_wb_q    <= '0;
            alu_wb_q   <= '0;
            mem_wb_q   <= '0;
            instr_wb_q <= '0;
            valid_wb_q <= 1'b0;
            err_wb_q   <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pc_wb_q    <= pc_wb_d;
            alu_wb_q   <= alu_wb_d;
            mem_wb_q   <= mem_wb_d;
            instr_wb_q <= instr_wb_d;
            valid_wb_q <= valid_wb_d;
            err_wb_q   <= err_wb_d;
            err_code_q <= err_code_d;
        end
    end

    assign pc_wb       = pc_wb_q;
    assign alu_wb      = alu_wb_q;
    assign mem_wb      = mem_wb_q;
    assign instr_wb    = instr_wb_q;
    assign valid_wb    = valid_wb_q;
    assign err_wb      = err_wb_q;
    assign err_code_wb = err_code_q;
    assign forward_mem = (instr_wb_q[6:0] == OPC_LOAD) ? mem_wb_q : alu_wb_q;
endmodule

// File: tb/tb_memory_access.sv
// Randomized bench for memory_access against a transaction-level reference model.
module tb_memory_access;
    localparam int T = 16;
    localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, ADD = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc_mem, alu_mem, rs2_mem, instr_mem;
    logic        valid_mem, stall_mem;
    logic [31:0] pc_wb, alu_wb, mem_wb, instr_wb, forward_mem;
    logic        valid_wb, err_wb;
    logic [1:0]  err_code_wb;
    int n_chk = 0, n_err = 0;

    memory_access_if bus ();

    memory_access #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst),
        .pc_mem(pc_mem), .alu_mem(alu_mem), .rs2_mem(rs2_mem), .instr_mem(instr_mem),
        .valid_mem(valid_mem), .stall_mem(stall_mem), .bus(bus.master),
        .pc_wb(pc_wb), .alu_wb(alu_wb), .mem_wb(mem_wb), .instr_wb(instr_wb),
        .valid_wb(valid_wb), .err_wb(err_wb), .err_code_wb(err_code_wb),
        .forward_mem(forward_mem)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3);
        logic [31:0] r;
        r = $urandom;
        r[6:0] = opc;
        r[14:12] = f3;
        return r;
    endfunction

    function automatic logic [31:0] eff_addr(input logic [2:0] f3, input logic [31:0] a);
        int w;
        w = f3 % 4;
        if (w == 0) return a;
        if (w == 1) return a - (a % 2);
        return a - (a % 4);
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [31:0] a);
        int w;
        w = f3 % 4;
        if (w == 1) return (a % 2) != 0;
        if (w >= 2) return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] ea);
        int w;
        w = f3 % 4;
        if (w == 0) return 4'(1 << (ea % 4));
        if (w == 1) return 4'(3 << (ea % 4));
        return 4'hF;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] rs2);
        int w;
        w = f3 % 4;
        if (w == 0) return (rs2 % 256) * 32'h01010101;
        if (w == 1) return (rs2 % 65536) * 32'h00010001;
        return rs2;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] ea,
                                             input logic [31:0] rd);
        logic [31:0] v, b, h;
        v = rd / (32'd1 << ((ea % 4) * 8));
        b = v % 256;
        h = v % 65536;
        case (f3)
            3'd0: return (b >= 128) ? b + 32'hFFFFFF00 : b;
            3'd1: return (h >= 32768) ? h + 32'hFFFF0000 : h;
            3'd4: return b;
            3'd5: return h;
            default: return rd;
        endcase
    endfunction

    // ack_at: cycle index (0 = issue cycle) at which dmem_ack is raised; -1 = never
    task automatic do_op(input string tag, input logic vld, input logic [31:0] instr,
                         input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] rs2,
                         input logic [31:0] rdata, input int ack_at);
        logic ld, st, mem, trap, acc, tmo;
        logic [2:0] f3;
        logic [31:0] ea, em;
        int fin;
        f3  = instr[14:12];
        ld  = instr[6:0] == LD;
        st  = instr[6:0] == ST;
        mem = ld || st;
        ea  = eff_addr(f3, alu);
        trap = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        trap = mem && misaligned(f3, alu);
        ea   = alu;
`endif
        acc = vld && mem && !trap;
        tmo = acc && !(ack_at >= 0 && ack_at <= T);
        fin = !acc ? 0 : (tmo ? T : ack_at);
        em  = (ld && acc && !tmo) ? exp_load(f3, ea, rdata) : 32'h0;
        for (int c = 0; c <= fin; c++) begin
            @(negedge clk);
            if (c == 0) begin
                valid_mem = vld; instr_mem = instr; pc_mem = pc; alu_mem = alu; rs2_mem = rs2;
            end
            bus.dmem_ack   = acc ? (c == ack_at) : 1'($urandom);
            bus.dmem_rdata = (acc && c == ack_at) ? rdata : $urandom;
            #1;
            chk({tag, " req"}, bus.dmem_req, acc);
            chk({tag, " stall"}, stall_mem, c < fin);
            if (acc) begin
                chk({tag, " addr"}, bus.dmem_addr, ea);
                chk({tag, " we"}, bus.dmem_we, st);
                if (st) begin
                    chk({tag, " be"}, bus.dmem_be, exp_be(f3, ea));
                    chk({tag, " wdata"}, bus.dmem_wdata, exp_wdata(f3, rs2));
                end
            end
            @(posedge clk);
            #1;
            if (c < fin) chk({tag, " bubble"}, valid_wb, 1'b0);
            else begin
                chk({tag, " valid_wb"}, valid_wb, vld);
                if (vld) begin
                    chk({tag, " pc_wb"}, pc_wb, pc);
                    chk({tag, " alu_wb"}, alu_wb, alu);
                    chk({tag, " instr_wb"}, instr_wb, instr);
                    chk({tag, " mem_wb"}, mem_wb, em);
                    chk({tag, " err_wb"}, err_wb, tmo || trap);
                    chk({tag, " err_code"}, err_code_wb, tmo ? 2'd1 : (trap ? 2'd2 : 2'd0));
                    chk({tag, " fwd"}, forward_mem, ld ? em : alu);
                end
            end
        end
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        logic [2:0]  ldf3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        logic [6:0]  oth  [4] = '{7'b0110011, 7'b0010011, 7'b1100011, 7'b0110111};
        logic [31:0] ins;
        int kind, sel, ack;

        valid_mem = 1'b0; instr_mem = '0; pc_mem = '0; alu_mem = '0; rs2_mem = '0;
        bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;
        #1 rst = 1'b1;
        #1;
        chk("rst valid_wb", valid_wb, 1'b0);
        chk("rst err_wb", err_wb, 1'b0);
        chk("rst err_code", err_code_wb, 2'd0);
        chk("rst pc_wb", pc_wb, 32'h0);
        chk("rst mem_wb", mem_wb, 32'h0);
        chk("rst req", bus.dmem_req, 1'b0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        do_op("add", 1'b1, mk(ADD, 3'd0), 32'h1000, 32'h10, 32'h5, 32'h0, 0);
        do_op("lb", 1'b1, mk(LD, 3'd0), 32'h1004, 32'h103, 32'h0, 32'h80FFFFFF, 3);
        do_op("lbu", 1'b1, mk(LD, 3'd4), 32'h1008, 32'h103, 32'h0, 32'h80FFFFFF, 3);
        do_op("sh", 1'b1, mk(ST, 3'd1), 32'h100C, 32'h102, 32'h1234ABCD, 32'h0, 0);
        do_op("lw_tmo", 1'b1, mk(LD, 3'd2), 32'h1010, 32'h200, 32'h0, 32'h0, -1);
        do_op("lw_ack_at_tmo", 1'b1, mk(LD, 3'd2), 32'h1014, 32'h204, 32'h0, 32'hCAFEF00D, T);
        do_op("lw_mis", 1'b1, mk(LD, 3'd2), 32'h1018, 32'h101, 32'h0, 32'h11223344, 0);
        do_op("idle_ack", 1'b0, mk(LD, 3'd2), 32'h101C, 32'h300, 32'h0, 32'h0, 0);

        // reset while a load is waiting
        @(negedge clk);
        valid_mem = 1'b1; instr_mem = mk(LD, 3'd2); alu_mem = 32'h400; pc_mem = 32'h2000;
        bus.dmem_ack = 1'b0;
        @(posedge clk); @(posedge clk); #3;
        chk("wait req", bus.dmem_req, 1'b1);
        rst = 1'b1;
        #1;
        chk("midrst req", bus.dmem_req, 1'b0);
        chk("midrst valid_wb", valid_wb, 1'b0);
        chk("midrst stall", stall_mem, 1'b0);
        chk("midrst alu_wb", alu_wb, 32'h0);
        @(negedge clk);
        valid_mem = 1'b0; bus.dmem_ack = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("late ack", valid_wb, 1'b0);
        end

        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 3);
            sel  = $urandom_range(0, 9);
            ack  = (sel <= 6) ? $urandom_range(0, 4) : (sel == 7) ? T :
                   (sel == 8) ? -1 : $urandom_range(5, T - 1);
            case (kind)
                0: ins = mk(LD, ldf3[$urandom_range(0, 4)]);
                1: ins = mk(ST, 3'($urandom_range(0, 2)));
                2: ins = mk(oth[$urandom_range(0, 3)], 3'($urandom));
                default: ins = mk(LD, ldf3[$urandom_range(0, 4)]);
            endcase
            do_op("rnd", kind != 3, ins, $urandom, $urandom, $urandom, $urandom, ack);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/memory_access.md
MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, max cycles in WAIT before bus error.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports pc_mem, alu_mem, rs2_mem, instr_mem  input  XLEN each  execute-stage pipeline registers.
REQ-005 SHALL have port valid_mem  input  1  qualifies instr_mem.
REQ-006 SHALL have port stall_mem  output  1  upstream must hold all *_mem inputs while high.
REQ-007 SHALL have ports dmem_req, dmem_we  output  1 each  request strobe, write flag.
REQ-008 SHALL have ports dmem_addr, dmem_wdata  output  XLEN each; dmem_be  output  4  byte enables.
REQ-009 SHALL have ports dmem_ack  input  1; dmem_rdata  input  XLEN.
REQ-010 SHALL have ports pc_wb, alu_wb, mem_wb, instr_wb  output  XLEN each  writeback registers.
REQ-011 SHALL have ports valid_wb, err_wb  output  1 each; err_code_wb  output  2  (0 none, 1 bus timeout, 2 misaligned).
REQ-012 SHALL have port forward_mem  output  XLEN  = mem_wb for loads, alu_wb otherwise.

Function
REQ-013 SHALL decode load when instr_mem[6:0]=0000011, store when 0100011, width/sign from instr_mem[14:12].
REQ-014 SHALL drive dmem_req combinationally = (IDLE & valid_mem & memop) | WAIT; dmem_addr = alu_mem; dmem_we = store.
REQ-015 SHALL assert stall_mem = dmem_req & ~dmem_ack & ~timeout.
REQ-016 FSM SHALL have states IDLE, WAIT; IDLE->WAIT on req without ack; WAIT->IDLE on ack or timeout; ack in IDLE completes with zero wait.
REQ-017 SHALL count WAIT cycles; at count = TIMEOUT_CYCLES-1 without ack, SHALL retire with err_wb=1, err_code_wb=1, counter cleared.
REQ-018 Non-memory ops SHALL pass to *_wb in 1 cycle, valid_wb=valid_mem, no dmem_req.
REQ-019 While stall_mem high, valid_wb SHALL be 0 (bubble); retire cycle registers outputs, valid_wb=1.
REQ-020 Stores: SB be=0001<<addr[1:0], wdata byte replicated x4; SH be=0011<<(2*addr[1]), halfword replicated x2; SW be=1111.
REQ-021 Loads: SHALL select byte/half by addr low bits; LB/LH sign-extend, LBU/LHU zero-extend, LW raw; result to mem_wb.
REQ-022 Ack arriving simultaneously with timeout count SHALL win (normal completion).
REQ-023 dmem_ack outside an active request SHALL be ignored.

Reset
REQ-024 On rst, state=IDLE, counter=0, all *_wb outputs=0, valid_wb=0, err_wb=0, err_code_wb=0, immediately and asynchronously.
REQ-025 Reset during WAIT SHALL drop dmem_req in the same cycle and discard the pending transaction; late ack ignored.

Configuration
REQ-026 With MEM_MISALIGN_TRAP_EN defined, misaligned LH/LHU/SH (addr[0]=1) or LW/SW (addr[1:0]!=0) SHALL issue no dmem_req and retire in 1 cycle with err_wb=1, err_code_wb=2.
REQ-027 Without MEM_MISALIGN_TRAP_EN, offending low address bits SHALL be cleared and the access performed normally; err_code 2 never produced.

Structure
REQ-028 Opcode, funct3 load/store codes, err codes and FSM state enum SHALL reside in shared package rv_pkg alongside existing XLEN constants.
REQ-029 Load extraction/extension SHALL be sub-module load_align (inputs rdata, addr[1:0], funct3; output XLEN).

Verification
REQ-030 ADD instr, alu_mem=0x10 -> next cycle valid_wb=1, alu_wb=0x10, dmem_req never asserted.
REQ-031 LB addr=0x103, ack after 3 cycles, rdata=0x80FFFFFF -> stall 3 cycles, mem_wb=0xFFFFFF80; LBU same -> 0x00000080.
REQ-032 SH addr=0x102, rs2=0x1234ABCD, zero-wait ack -> dmem_be=1100, dmem_wdata=0xABCDABCD, no stall.
REQ-033 LW, ack withheld -> after 16 WAIT cycles err_wb=1, err_code_wb=1, stall released, FSM IDLE.
REQ-034 LW addr=0x101: with macro -> err_code_wb=2, no dmem_req; without -> dmem_addr=0x100.
REQ-035 rst asserted mid-WAIT -> dmem_req=0 and valid_wb=0 same cycle; subsequent ack produces no retire.
